// File: rtl/hazard3_muldiv_pkg.sv
// Muldiv issue-stage shared definitions: FSM state encoding and the op-class
// helpers used by the result cache (hit test, high/low result select).
package hazard3_muldiv_pkg;

  import hazard3_ops_pkg::*;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StBusy,
    StDone
  } md_state_e;

  // A cached result can serve new_op if the muldiv would have produced the
  // wanted half for the same operands: div/rem of one signedness share a run,
  // and the low product word does not depend on operand signedness.
  function automatic logic op_hit(input logic [W_M_OP-1:0] new_op,
                                  input logic [W_M_OP-1:0] old_op);
    logic new_s, old_s, new_u, old_u, old_mul;
    new_s   = (new_op == M_OP_DIV)  || (new_op == M_OP_REM);
    old_s   = (old_op == M_OP_DIV)  || (old_op == M_OP_REM);
    new_u   = (new_op == M_OP_DIVU) || (new_op == M_OP_REMU);
    old_u   = (old_op == M_OP_DIVU) || (old_op == M_OP_REMU);
    old_mul = (old_op == M_OP_MUL)  || (old_op == M_OP_MULH) ||
              (old_op == M_OP_MULHSU) || (old_op == M_OP_MULHU);
    op_hit  = (new_op == old_op) || (new_s && old_s) || (new_u && old_u) ||
              ((new_op == M_OP_MUL) && old_mul);
  endfunction

  // 1: result comes from the high word (upper product / remainder).
  function automatic logic op_sel_hi(input logic [W_M_OP-1:0] op);
    op_sel_hi = !((op == M_OP_MUL) || (op == M_OP_DIV) || (op == M_OP_DIVU));
  endfunction

endpackage

// File: rtl/hazard3_ops_pkg.sv
// Shared muldiv op encodings (M_OP_*), matching the RV32M funct3 field.
// Kept separate from the issue-stage package so other units can reuse them.
package hazard3_ops_pkg;

  localparam int unsigned W_M_OP = 3;

  localparam logic [W_M_OP-1:0] M_OP_MUL    = 3'h0;
  localparam logic [W_M_OP-1:0] M_OP_MULH   = 3'h1;
  localparam logic [W_M_OP-1:0] M_OP_MULHSU = 3'h2;
  localparam logic [W_M_OP-1:0] M_OP_MULHU  = 3'h3;
  localparam logic [W_M_OP-1:0] M_OP_DIV    = 3'h4;
  localparam logic [W_M_OP-1:0] M_OP_DIVU   = 3'h5;
  localparam logic [W_M_OP-1:0] M_OP_REM    = 3'h6;
  localparam logic [W_M_OP-1:0] M_OP_REMU   = 3'h7;

endpackage

// File: rtl/hazard3_muldiv_issue_if.sv
// Bundle of the issue stage's buses: upstream request, flush, muldiv command
// and result, downstream response.
//   slave  : the issue stage (takes requests, drives muldiv and response)
//   master : the surrounding pipeline / muldiv / consumer
interface hazard3_muldiv_issue_if #(
  parameter int unsigned W_DATA  = 32,
  parameter int unsigned W_MULOP = 3,
  parameter int unsigned W_TAG   = 5
);
  logic               req_vld;
  logic               req_rdy;
  logic [W_MULOP-1:0] req_op;
  logic [W_DATA-1:0]  req_a;
  logic [W_DATA-1:0]  req_b;
  logic [W_TAG-1:0]   req_tag;
  logic               flush;
  logic [W_MULOP-1:0] md_op;
  logic               md_op_vld;
  logic               md_op_rdy;
  logic               md_op_kill;
  logic [W_DATA-1:0]  md_op_a;
  logic [W_DATA-1:0]  md_op_b;
  logic [W_DATA-1:0]  md_result_h;
  logic [W_DATA-1:0]  md_result_l;
  logic               md_result_vld;
  logic               rsp_vld;
  logic               rsp_rdy;
  logic [W_DATA-1:0]  rsp_data;
  logic [W_TAG-1:0]   rsp_tag;

  modport slave (
    input  req_vld, req_op, req_a, req_b, req_tag, flush, md_op_rdy,
           md_result_h, md_result_l, md_result_vld, rsp_rdy,
    output req_rdy, md_op, md_op_vld, md_op_kill, md_op_a, md_op_b,
           rsp_vld, rsp_data, rsp_tag
  );

  modport master (
    output req_vld, req_op, req_a, req_b, req_tag, flush, md_op_rdy,
           md_result_h, md_result_l, md_result_vld, rsp_rdy,
    input  req_rdy, md_op, md_op_vld, md_op_kill, md_op_a, md_op_b,
           rsp_vld, rsp_data, rsp_tag
  );
endinterface

// File: rtl/hazard3_muldiv_rcache.sv
// One-entry result cache for the muldiv issue stage. Holds the operands, op
// and both result words of the last completed muldiv run, and answers a
// combinational lookup with a hit flag and the selected result word.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   i_clr              invalidate the entry
//   i_wr, i_wr_*       store a completed run (op, operands, result h/l)
//   i_lk_op/a/b        lookup key
//   o_hit, o_lk_data   lookup hit and the result word for i_lk_op
module hazard3_muldiv_rcache
  import hazard3_muldiv_pkg::*;
#(
  parameter int unsigned W_DATA  = 32,
  parameter int unsigned W_MULOP = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_wr,
  input  logic [W_MULOP-1:0] i_wr_op,
  input  logic [W_DATA-1:0]  i_wr_a,
  input  logic [W_DATA-1:0]  i_wr_b,
  input  logic [W_DATA-1:0]  i_wr_h,
  input  logic [W_DATA-1:0]  i_wr_l,
  input  logic [W_MULOP-1:0] i_lk_op,
  input  logic [W_DATA-1:0]  i_lk_a,
  input  logic [W_DATA-1:0]  i_lk_b,
  output logic               o_hit,
  output logic [W_DATA-1:0]  o_lk_data
);

  logic               r_vld;
  logic [W_MULOP-1:0] r_op;
  logic [W_DATA-1:0]  r_a;
  logic [W_DATA-1:0]  r_b;
  logic [W_DATA-1:0]  r_h;
  logic [W_DATA-1:0]  r_l;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_h   <= '0;
      r_l   <= '0;
    end else if (i_clr) begin
      r_vld <= 1'b0;
    end else if (i_wr) begin
      r_vld <= 1'b1;
      r_op  <= i_wr_op;
      r_a   <= i_wr_a;
      r_b   <= i_wr_b;
      r_h   <= i_wr_h;
      r_l   <= i_wr_l;
    end
  end

  assign o_hit = r_vld && (i_lk_a == r_a) && (i_lk_b == r_b) &&
                 op_hit(3'(i_lk_op), 3'(r_op));
  assign o_lk_data = op_sel_hi(3'(i_lk_op)) ? r_h : r_l;

endmodule

// File: rtl/hazard3_muldiv_issue.sv
// Muldiv issue stage: accepts one request at a time, answers it from the
// one-entry result cache when possible, otherwise issues it to the sequential
// muldiv and waits for the result, then holds the response until consumed.
// Ports:
//   clk, rst  clock, synchronous active-high reset (wins over everything)
//   io_bus    request / flush / muldiv command+result / response bundle
module hazard3_muldiv_issue
  import hazard3_muldiv_pkg::*;
#(
  parameter int unsigned W_DATA  = 32,
  parameter int unsigned W_MULOP = 3,
  parameter int unsigned W_TAG   = 5
) (
  input logic                   clk,
  input logic                   rst,
  hazard3_muldiv_issue_if.slave io_bus
);

  md_state_e          r_state, w_state_nxt;
  logic [W_MULOP-1:0] r_op;
  logic [W_DATA-1:0]  r_a;
  logic [W_DATA-1:0]  r_b;
  logic [W_TAG-1:0]   r_tag;
  logic [W_DATA-1:0]  r_rsp_data;

  logic              w_req_rdy;
  logic              w_accept;
  logic              w_hit;
  logic [W_DATA-1:0] w_hit_data;
  logic              w_capture;
  logic [W_DATA-1:0] w_res_sel;

  assign w_req_rdy = (r_state == StIdle) && !io_bus.flush;
  assign w_accept  = io_bus.req_vld && w_req_rdy;
  // A result arriving together with flush is dropped, not cached.
  assign w_capture = (r_state == StBusy) && io_bus.md_result_vld && !io_bus.flush;
  assign w_res_sel = op_sel_hi(3'(r_op)) ? io_bus.md_result_h : io_bus.md_result_l;

  // Lookup is keyed on the incoming request so a hit can skip ISSUE entirely.
  hazard3_muldiv_rcache #(
    .W_DATA  (W_DATA),
    .W_MULOP (W_MULOP)
  ) u_rcache (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (io_bus.flush),
    .i_wr      (w_capture),
    .i_wr_op   (r_op),
    .i_wr_a    (r_a),
    .i_wr_b    (r_b),
    .i_wr_h    (io_bus.md_result_h),
    .i_wr_l    (io_bus.md_result_l),
    .i_lk_op   (io_bus.req_op),
    .i_lk_a    (io_bus.req_a),
    .i_lk_b    (io_bus.req_b),
    .o_hit     (w_hit),
    .o_lk_data (w_hit_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_nxt = w_hit ? StDone : StIssue;
      StIssue: if (io_bus.md_op_vld && io_bus.md_op_rdy) w_state_nxt = StBusy;
      StBusy:  if (io_bus.md_result_vld) w_state_nxt = StDone;
      StDone:  if (io_bus.rsp_rdy) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
    if (io_bus.flush) w_state_nxt = StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_tag      <= '0;
      r_rsp_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op  <= io_bus.req_op;
        r_a   <= io_bus.req_a;
        r_b   <= io_bus.req_b;
        r_tag <= io_bus.req_tag;
        if (w_hit) r_rsp_data <= w_hit_data;
      end
      if (w_capture) r_rsp_data <= w_res_sel;
    end
  end

  assign io_bus.req_rdy    = w_req_rdy;
  assign io_bus.md_op      = r_op;
  assign io_bus.md_op_a    = r_a;
  assign io_bus.md_op_b    = r_b;
  assign io_bus.md_op_vld  = (r_state == StIssue) && !io_bus.flush;
  assign io_bus.md_op_kill = io_bus.flush && ((r_state == StIssue) || (r_state == StBusy));
  assign io_bus.rsp_vld    = (r_state == StDone);
  assign io_bus.rsp_data   = r_rsp_data;
  assign io_bus.rsp_tag    = r_tag;

endmodule

// File: tb/tb_hazard3_muldiv_issue.sv
// Bench for hazard3_muldiv_issue: a behavioural muldiv answers issued ops,
// a driver pushes expected responses into a scoreboard, and a monitor pops and
// compares them whenever a response is consumed.
module tb_hazard3_muldiv_issue;

  localparam int OP_MUL = 0, OP_MULH = 1, OP_MULHSU = 2, OP_MULHU = 3;
  localparam int OP_DIV = 4, OP_DIVU = 5, OP_REM = 6, OP_REMU = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard3_muldiv_issue_if #(.W_DATA(32), .W_MULOP(3), .W_TAG(5)) bus ();

  hazard3_muldiv_issue #(.W_DATA(32), .W_MULOP(3), .W_TAG(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    bit          hit;
    int          md_snap;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_vec = 0, n_err = 0, cyc = 0, md_cnt = 0;

  // Model cache: which run the DUT should have cached.
  bit          c_vld = 0;
  logic [31:0] c_a, c_b;
  int          c_op;

  bit hold_low = 0;
  int force_lat = -1;
  int rdy_mode = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  // RISC-V M-extension reference semantics.
  function automatic logic [31:0] ref_op(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
      OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      OP_MULHSU: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
      OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      OP_DIV:    return (b == 0) ? 32'hffffffff : 32'(sa / sb);
      OP_DIVU:   return (b == 0) ? 32'hffffffff : a / b;
      OP_REM:    return (b == 0) ? a : 32'(sa % sb);
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit predict_hit(input int op, input logic [31:0] a, input logic [31:0] b);
    if (!c_vld || a != c_a || b != c_b) return 0;
    if (op == c_op) return 1;
    if ((op == OP_DIV || op == OP_REM) && (c_op == OP_DIV || c_op == OP_REM)) return 1;
    if ((op == OP_DIVU || op == OP_REMU) && (c_op == OP_DIVU || c_op == OP_REMU)) return 1;
    if (op == OP_MUL && c_op <= OP_MULHU) return 1;
    return 0;
  endfunction

  // Behavioural sequential muldiv: full product or quotient/remainder pair.
  bit m_busy = 0;
  int m_lat;
  logic [31:0] m_h, m_l;
  always @(negedge clk) begin
    bus.md_result_vld = 1'b0;
    if (rst) begin
      m_busy = 0;
    end else if (m_busy) begin
      if (bus.md_op_kill) m_busy = 0;
      else if (m_lat == 0) begin
        bus.md_result_vld = 1'b1;
        bus.md_result_h   = m_h;
        bus.md_result_l   = m_l;
        m_busy = 0;
      end else m_lat--;
    end else begin
      bus.md_op_rdy = (rdy_mode == 1) ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (bus.md_op_vld && bus.md_op_rdy) begin
        md_cnt++;
        if (bus.md_op <= 3'(OP_MULHU)) begin
          m_l = ref_op(OP_MUL, bus.md_op_a, bus.md_op_b);
          m_h = ref_op(int'(bus.md_op), bus.md_op_a, bus.md_op_b);
          if (bus.md_op == 3'(OP_MUL)) m_h = ref_op(OP_MULHU, bus.md_op_a, bus.md_op_b);
        end else if (bus.md_op == 3'(OP_DIV) || bus.md_op == 3'(OP_REM)) begin
          m_l = ref_op(OP_DIV, bus.md_op_a, bus.md_op_b);
          m_h = ref_op(OP_REM, bus.md_op_a, bus.md_op_b);
        end else begin
          m_l = ref_op(OP_DIVU, bus.md_op_a, bus.md_op_b);
          m_h = ref_op(OP_REMU, bus.md_op_a, bus.md_op_b);
        end
        m_lat  = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
        m_busy = 1;
      end else if ($urandom_range(0, 7) == 0) begin
        // Stray result strobe outside BUSY; must be ignored.
        bus.md_result_vld = 1'b1;
        bus.md_result_h   = $urandom;
        bus.md_result_l   = $urandom;
      end
    end
  end

  // Response monitor / scoreboard checker.
  bit p_vld = 0, p_rdy = 0;
  logic [31:0] p_data;
  logic [4:0] p_tag;
  always @(negedge clk) begin
    if (rst) begin
      p_vld = 0;
    end else begin
      bus.rsp_rdy = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (bus.flush) chk1("md_vld_under_flush", bus.md_op_vld, 1'b0);
      else chk1("kill_without_flush", bus.md_op_kill, 1'b0);
      if (p_vld && !p_rdy) begin
        chk1("rsp_vld_hold", bus.rsp_vld, 1'b1);
        chk("rsp_data_hold", bus.rsp_data, p_data);
        chk("rsp_tag_hold", {27'b0, bus.rsp_tag}, {27'b0, p_tag});
      end
      if (bus.rsp_vld) begin
        chk1("req_rdy_in_done", bus.req_rdy, 1'b0);
        if (!p_vld && sb.size() != 0 && sb[0].hit)
          chk("hit_latency", 32'(cyc - sb[0].acc_cyc), 32'd1);
        if (bus.rsp_rdy) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_rsp: got data %h tag %0d, none expected", bus.rsp_data,
                     bus.rsp_tag);
          end else begin
            mon_e = sb.pop_front();
            chk("rsp_data", bus.rsp_data, mon_e.data);
            chk("rsp_tag", {27'b0, bus.rsp_tag}, {27'b0, mon_e.tag});
            chk("md_issue_count", 32'(md_cnt - mon_e.md_snap), mon_e.hit ? 32'd0 : 32'd1);
          end
        end
      end
      p_vld  = bus.rsp_vld;
      p_rdy  = bus.rsp_rdy;
      p_data = bus.rsp_data;
      p_tag  = bus.rsp_tag;
    end
  end

  task automatic send(input int op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input bit push);
    exp_t e;
    int t;
    @(posedge clk);
    #1;
    bus.req_vld = 1'b1;
    bus.req_op  = 3'(op);
    bus.req_a   = a;
    bus.req_b   = b;
    bus.req_tag = tag;
    t = 0;
    @(negedge clk);
    while (!bus.req_rdy && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_rdy) begin
      n_vec++;
      n_err++;
      $display("FAIL req_accept_timeout: req_rdy got 0 expected 1");
    end else begin
      e.data = ref_op(op, a, b);
      e.tag = tag;
      e.hit = predict_hit(op, a, b);
      e.md_snap = md_cnt;
      e.acc_cyc = cyc;
      if (push) sb.push_back(e);
      if (!e.hit) begin
        c_vld = 1; c_a = a; c_b = b; c_op = op;
      end
    end
    @(posedge clk);
    #1;
    bus.req_vld = 1'b0;
    bus.req_op  = 3'($urandom);
    bus.req_a   = $urandom;
    bus.req_b   = $urandom;
    bus.req_tag = 5'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    while ((sb.size() != 0 || bus.rsp_vld) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0 || bus.rsp_vld) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'd7;
      3: return 32'hffffffff;
      4: return 32'h80000000;
      5: return 32'hfffffff9;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int snap, t, op;
    logic [31:0] a, b;
    bus.req_vld = 0; bus.req_op = 0; bus.req_a = 0; bus.req_b = 0; bus.req_tag = 0;
    bus.flush = 0; bus.md_op_rdy = 0; bus.md_result_h = 0; bus.md_result_l = 0;
    bus.md_result_vld = 0; bus.rsp_rdy = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk1("rst_req_rdy", bus.req_rdy, 1'b1);
    chk1("rst_rsp_vld", bus.rsp_vld, 1'b0);
    chk1("rst_md_op_vld", bus.md_op_vld, 1'b0);
    chk1("rst_md_op_kill", bus.md_op_kill, 1'b0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_md_op_a", bus.md_op_a, 32'd0);

    // DIVU miss then REMU hit on the same operands.
    send(OP_DIVU, 100, 7, 5'd1, 1);
    drain();
    send(OP_REMU, 100, 7, 5'd2, 1);
    drain();
    // MULHU then MUL served from the cached low product word.
    send(OP_MULHU, 32'hffffffff, 2, 5'd3, 1);
    drain();
    send(OP_MUL, 32'hffffffff, 2, 5'd4, 1);
    drain();

    // Flush together with req_vld must not accept.
    @(posedge clk);
    #1 bus.flush = 1; bus.req_vld = 1; bus.req_op = 3'(OP_DIV); bus.req_a = 9; bus.req_b = 2;
    @(negedge clk);
    chk1("flush_req_rdy", bus.req_rdy, 1'b0);
    @(posedge clk);
    #1 bus.flush = 0; bus.req_vld = 0; c_vld = 0;
    @(negedge clk);
    chk1("flush_no_accept_issue", bus.md_op_vld, 1'b0);
    chk1("flush_no_accept_rsp", bus.rsp_vld, 1'b0);

    // Flush while BUSY kills the op and clears the cache.
    force_lat = 20;
    snap = md_cnt;
    send(OP_DIV, 50, 3, 5'd5, 0);
    t = 0;
    while (md_cnt == snap && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("busy_reached", 32'(md_cnt - snap), 32'd1);
    @(posedge clk);
    #1 bus.flush = 1;
    @(negedge clk);
    chk1("busy_flush_kill", bus.md_op_kill, 1'b1);
    @(posedge clk);
    #1 bus.flush = 0; c_vld = 0;
    @(negedge clk);
    chk1("post_flush_idle", bus.req_rdy, 1'b1);
    chk1("post_flush_no_rsp", bus.rsp_vld, 1'b0);
    force_lat = -1;
    repeat (4) @(negedge clk);
    send(OP_DIV, 50, 3, 5'd6, 1);
    drain();

    // Stall the consumer for 5 cycles; monitor checks stability.
    hold_low = 1;
    send(OP_MULHSU, 32'hfffffffd, 5, 5'd7, 1);
    t = 0;
    while (!bus.rsp_vld && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk1("stall_rsp_vld", bus.rsp_vld, 1'b1);
    repeat (5) @(negedge clk);
    hold_low = 0;
    drain();

    // Reset while stuck in ISSUE invalidates the cache.
    send(OP_DIVU, 100, 7, 5'd8, 1);
    drain();
    rdy_mode = 1;
    send(OP_MUL, 3, 5, 5'd9, 0);
    t = 0;
    while (!bus.md_op_vld && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk1("issue_reached", bus.md_op_vld, 1'b1);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0; c_vld = 0; rdy_mode = 0;
    @(negedge clk);
    chk1("rst_issue_md_vld", bus.md_op_vld, 1'b0);
    chk1("rst_issue_req_rdy", bus.req_rdy, 1'b1);
    chk1("rst_issue_rsp_vld", bus.rsp_vld, 1'b0);
    send(OP_REMU, 100, 7, 5'd10, 1);
    drain();

    // Signedness differs: REMU must not reuse a DIV run.
    send(OP_DIV, 32'hfffffff9, 2, 5'd11, 1);
    drain();
    send(OP_REMU, 32'hfffffff9, 2, 5'd12, 1);
    drain();

    // Randomised traffic with frequent operand reuse to exercise hits.
    a = 0;
    b = 0;
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        a = pick();
        b = pick();
      end
      send(op, a, b, 5'($urandom), 1);
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard3_muldiv_issue.md
HAZARD3_MULDIV_ISSUE -- requirements
Module: hazard3_muldiv_issue

Interface
REQ-001 SHALL take parameter W_DATA, default 32: operand/result width.
REQ-002 SHALL take parameter W_MULOP, default 3: op code width, using the M_OP_* encodings from the shared ops include.
REQ-003 SHALL take parameter W_TAG, default 5: destination register tag width.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_vld in 1 / req_rdy out 1: upstream request handshake.
REQ-007 req_op in W_MULOP / req_a in W_DATA / req_b in W_DATA / req_tag in W_TAG: request payload.
REQ-008 flush  in  1  discard the in-flight request and response, invalidate the cache.
REQ-009 md_op out W_MULOP / md_op_vld out 1 / md_op_rdy in 1 / md_op_kill out 1 / md_op_a out W_DATA / md_op_b out W_DATA: drive the sequential muldiv.
REQ-010 md_result_h in W_DATA / md_result_l in W_DATA / md_result_vld in 1: results returned by the muldiv.
REQ-011 rsp_vld out 1 / rsp_rdy in 1 / rsp_data out W_DATA / rsp_tag out W_TAG: downstream response handshake.

Function
REQ-012 SHALL implement states IDLE, ISSUE, BUSY, DONE.
REQ-013 req_rdy SHALL be 1 only in IDLE with flush=0; acceptance SHALL register op, operands and tag.
REQ-014 Cache hit on acceptance: IDLE->DONE, with rsp_data from the cached result and no muldiv operation issued (latency 1 cycle).
REQ-015 Hit condition: cache valid, req_a and req_b equal the cached operands, and one of the following: same op; {DIV,REM} pair; {DIVU,REMU} pair; new op MUL with cached op any of MUL/MULH/MULHSU/MULHU.
REQ-016 Miss: IDLE->ISSUE; in ISSUE, md_op_vld=1 with the registered op/operands; on md_op_vld&&md_op_rdy -> BUSY.
REQ-017 In BUSY, md_op_vld=0; on md_result_vld=1 SHALL capture result_h/result_l, operands and op into the cache, set the cache valid, and go to DONE.
REQ-018 Result select: MUL, DIV, DIVU -> result_l; MULH, MULHSU, MULHU, REM, REMU -> result_h.
REQ-019 In DONE, rsp_vld=1 and rsp_data/rsp_tag stay stable until rsp_vld&&rsp_rdy; then -> IDLE.
REQ-020 flush SHALL force IDLE next cycle from any state, drop any pending response and clear the cache valid bit.
REQ-021 md_op_kill SHALL equal flush while in ISSUE or BUSY, else 0; md_op_vld SHALL be 0 whenever flush=1.
REQ-022 flush together with req_vld SHALL NOT accept the request.
REQ-023 md_result_vld outside BUSY SHALL be ignored.
REQ-024 No arithmetic is performed here; operands SHALL be passed through unmodified.

Reset
REQ-025 On rst, state SHALL be IDLE, and req_rdy=1, rsp_vld=0, md_op_vld=0, md_op_kill=0.
REQ-026 On rst, the cache valid bit SHALL clear and all data registers SHALL be 0.
REQ-027 rst SHALL take priority over flush and over all handshakes.

Structure
REQ-028 State encoding and the hit/result-select op-class functions SHALL live in a shared hazard3_muldiv_pkg include; M_OP_* SHALL remain in the existing ops include.
REQ-029 One sub-module is natural: hazard3_muldiv_rcache (operand/op compare plus result storage); the rest SHALL be flat.

Verification
REQ-030 Sequence: DIVU a=100, b=7 (miss) -> rsp_data=14 after md_result_vld; then REMU 100,7 -> hit, rsp_data=2 one cycle after acceptance, md_op_vld stays 0.
REQ-031 Sequence: MULHU a=0xFFFFFFFF, b=2 -> rsp_data=1; then MUL with the same operands -> hit, rsp_data=0xFFFFFFFE.
REQ-032 flush asserted in BUSY -> md_op_kill=1 for that cycle, IDLE next cycle, no rsp_vld; the same DIV reissued afterwards -> miss (cache cleared).
REQ-033 rsp_rdy=0 held for 5 cycles in DONE -> rsp_vld, rsp_data and rsp_tag stable; req_rdy=0 throughout.
REQ-034 rst asserted in ISSUE with md_op_rdy=0 -> next cycle IDLE, md_op_vld=0, cache invalid.
REQ-035 DIV a=-7, b=2 then REMU -7,2 -> REMU misses (signedness differs) and issues a new operation.
